// File: rtl/sevseg_reader.sv
// Samples a multiplexed two-digit, active-low seven-segment bus. It debounces each digit,
// decodes it to hex and publishes {digit0, digit1} frames through a valid/ack handshake.
module sevseg_reader #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg,
  input  logic [1:0] an,
  input  logic       ack,
  output logic [3:0] hex0,
  output logic [3:0] hex1,
  output logic       valid,
  output logic       err,
  output logic       overrun
);

  typedef enum logic {
    WAIT0,
    WAIT1
  } state_t;

  localparam logic [3:0] LP_STABLE    = 4'(STABLE_CYCLES);
  localparam logic [3:0] LP_STABLE_M1 = 4'(STABLE_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [6:0] r_seg;
  logic [6:0] r_seg_prev;
  logic [1:0] r_an;
  logic [1:0] r_an_prev;
  logic [3:0] r_cnt;
  logic [3:0] r_pend0;
  logic [3:0] r_pend1;
  logic       r_ferr;
  logic       r_done;
  logic [3:0] r_hex0;
  logic [3:0] r_hex1;
  logic       r_valid;
  logic       r_err;
  logic       r_overrun;

  logic       w_same;
  logic       w_event;
  logic [3:0] w_digit;
  logic       w_bad;
  logic       w_cap0;
  logic       w_cap1;
  logic       w_set_err;
  logic       w_complete;

  assign w_same  = ({r_an, r_seg} == {r_an_prev, r_seg_prev});
  // Fires only on the single edge where the saturating counter steps up to STABLE_CYCLES.
  assign w_event = w_same && (r_cnt == LP_STABLE_M1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg      <= 7'h7F;
      r_seg_prev <= 7'h7F;
      r_an       <= 2'b11;
      r_an_prev  <= 2'b11;
      r_cnt      <= '0;
    end else begin
      r_seg      <= seg;
      r_an       <= an;
      r_seg_prev <= r_seg;
      r_an_prev  <= r_an;
      if (!w_same)
        r_cnt <= 4'd1;
      else if (r_cnt != LP_STABLE)
        r_cnt <= r_cnt + 4'd1;
    end
  end

  always_comb begin
    w_bad = 1'b0;
    unique case (r_seg)
      7'h40: w_digit = 4'h0;
      7'h79: w_digit = 4'h1;
      7'h24: w_digit = 4'h2;
      7'h30: w_digit = 4'h3;
      7'h19: w_digit = 4'h4;
      7'h12: w_digit = 4'h5;
      7'h02: w_digit = 4'h6;
      7'h78: w_digit = 4'h7;
      7'h00: w_digit = 4'h8;
      7'h10: w_digit = 4'h9;
      7'h08: w_digit = 4'hA;
      7'h03: w_digit = 4'hB;
      7'h46: w_digit = 4'hC;
      7'h21: w_digit = 4'hD;
      7'h06: w_digit = 4'hE;
      7'h0E: w_digit = 4'hF;
      default: begin
        w_digit = 4'h0;
        w_bad   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= WAIT0;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cap0      = 1'b0;
    w_cap1      = 1'b0;
    w_set_err   = 1'b0;
    w_complete  = 1'b0;
    if (w_event) begin
      unique case (r_an)
        2'b10: begin
          w_cap0      = 1'b1;
          w_set_err   = w_bad;
          w_state_nxt = WAIT1;
        end
        2'b01: begin
          if (r_state == WAIT1) begin
            w_cap1      = 1'b1;
            w_set_err   = w_bad;
            w_complete  = 1'b1;
            w_state_nxt = WAIT0;
          end
        end
        2'b00: begin
          w_set_err   = 1'b1;
          w_state_nxt = WAIT0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend0   <= '0;
      r_pend1   <= '0;
      r_ferr    <= 1'b0;
      r_done    <= 1'b0;
      r_hex0    <= '0;
      r_hex1    <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_cap0) r_pend0 <= w_digit;
      if (w_cap1) r_pend1 <= w_digit;
      // The error flag is cleared by publication, but an error from this same edge must still be kept.
      r_ferr <= (r_done ? 1'b0 : r_ferr) | w_set_err;
      r_done <= w_complete;
      if (r_done) begin
        r_hex0  <= r_pend0;
        r_hex1  <= r_pend1;
        r_err   <= r_ferr;
        r_valid <= 1'b1;
        if (r_valid && !ack) r_overrun <= 1'b1;
      end else if (ack) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign hex0    = r_hex0;
  assign hex1    = r_hex1;
  assign valid   = r_valid;
  assign err     = r_err;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_sevseg_reader.sv
// Self-checking bench for sevseg_reader: directed scenarios plus randomized digit streams,
// compared against a run-length / frame-level reference model.
module tb_sevseg_reader;
  localparam int S = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] seg;
  logic [1:0] an;
  logic       ack;
  logic [3:0] hex0;
  logic [3:0] hex1;
  logic       valid;
  logic       err;
  logic       overrun;

  sevseg_reader #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .seg(seg), .an(an), .ack(ack),
    .hex0(hex0), .hex1(hex1), .valid(valid), .err(err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model state
  logic [8:0] m_prev;
  int         m_run;
  bit         m_w1, m_pub, m_ferr;
  int         m_p0, m_p1;
  int         exp_hex0, exp_hex1, exp_valid, exp_err, exp_ovr;

  function automatic void decode(input logic [6:0] s, output int v, output bit bad);
    v   = 0;
    bad = 1'b1;
    for (int i = 0; i < 16; i++)
      if (seg_tab[i] == s) begin
        v   = i;
        bad = 1'b0;
      end
  endfunction

  task automatic model_reset();
    m_prev = {2'b11, 7'h7F};
    m_run  = 1;
    m_w1 = 0; m_pub = 0; m_ferr = 0; m_p0 = 0; m_p1 = 0;
    exp_hex0 = 0; exp_hex1 = 0; exp_valid = 0; exp_err = 0; exp_ovr = 0;
  endtask

  // One rising edge: the decision sample is the input applied one edge earlier.
  task automatic model_edge(input logic [8:0] cur, input bit a);
    bit done;
    int v;
    bit bad;
    done = 0;
    if (m_pub) begin
      if (exp_valid != 0 && !a) exp_ovr = 1;
      exp_hex0 = m_p0; exp_hex1 = m_p1; exp_err = int'(m_ferr); exp_valid = 1;
      m_ferr = 0;
    end else if (a) begin
      exp_valid = 0;
    end
    if (m_run == S) begin
      decode(m_prev[6:0], v, bad);
      case (m_prev[8:7])
        2'b10: begin m_p0 = v; m_ferr |= bad; m_w1 = 1; end
        2'b01: if (m_w1) begin m_p1 = v; m_ferr |= bad; m_w1 = 0; done = 1; end
        2'b00: begin m_ferr = 1; m_w1 = 0; end
        default: ;
      endcase
    end
    m_pub = done;
    if (cur == m_prev) m_run = (m_run < 1000) ? m_run + 1 : m_run;
    else begin m_prev = cur; m_run = 1; end
  endtask

  task automatic check_outputs();
    check("hex0", 32'(hex0), 32'(exp_hex0));
    check("hex1", 32'(hex1), 32'(exp_hex1));
    check("valid", 32'(valid), 32'(exp_valid));
    check("err", 32'(err), 32'(exp_err));
    check("overrun", 32'(overrun), 32'(exp_ovr));
  endtask

  task automatic tick(input logic [1:0] a_n, input logic [6:0] s, input bit k);
    @(negedge clk);
    an = a_n; seg = s; ack = k;
    @(posedge clk);
    model_edge({a_n, s}, k);
    #1 check_outputs();
  endtask

  task automatic hold(input logic [1:0] a_n, input logic [6:0] s, input int n);
    for (int i = 0; i < n; i++) tick(a_n, s, 1'b0);
  endtask

  task automatic idle(input int n);
    hold(2'b11, 7'h7F, n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_hex0", 32'(hex0), 32'd0);
    check("rst_hex1", 32'(hex1), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset = 1'b1; an = 2'b11; seg = 7'h7F; ack = 1'b0;
    model_reset();
    #1;
    check("por_valid", 32'(valid), 32'd0);
    check("por_overrun", 32'(overrun), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle(3);

    // Basic frame 3,4 and ack
    hold(2'b10, 7'h30, 4); hold(2'b01, 7'h19, 4);
    idle(1);
    check("lat_valid_early", 32'(valid), 32'd0);
    idle(1);
    check("f34_valid", 32'(valid), 32'd1);
    check("f34_hex0", 32'(hex0), 32'h3);
    check("f34_hex1", 32'(hex1), 32'h4);
    check("f34_err", 32'(err), 32'd0);
    tick(2'b11, 7'h7F, 1'b1);
    check("f34_ack", 32'(valid), 32'd0);

    // Three stable cycles are not enough
    hold(2'b10, 7'h30, 3); hold(2'b10, 7'h12, 4); hold(2'b01, 7'h40, 4); idle(2);
    check("deb_hex0", 32'(hex0), 32'h5);
    check("deb_hex1", 32'(hex1), 32'h0);
    tick(2'b11, 7'h7F, 1'b1);

    // Undecodable digit 0
    hold(2'b10, 7'h7F, 4); hold(2'b01, 7'h40, 4); idle(2);
    check("bad_err", 32'(err), 32'd1);
    check("bad_hex0", 32'(hex0), 32'h0);
    check("bad_valid", 32'(valid), 32'd1);
    tick(2'b11, 7'h7F, 1'b1);

    // Overrun: two frames without ack
    hold(2'b10, 7'h79, 4); hold(2'b01, 7'h24, 4); idle(2);
    hold(2'b10, 7'h78, 4); hold(2'b01, 7'h00, 4); idle(2);
    check("ovr_hex0", 32'(hex0), 32'h7);
    check("ovr_hex1", 32'(hex1), 32'h8);
    check("ovr_flag", 32'(overrun), 32'd1);
    tick(2'b11, 7'h7F, 1'b1);
    check("ovr_sticky", 32'(overrun), 32'd1);

    // Reset between the digit-0 and digit-1 decodes
    hold(2'b10, 7'h30, 4); tick(2'b01, 7'h19, 1'b0);
    do_reset();
    hold(2'b01, 7'h19, 4); idle(3);
    check("rst_partial_valid", 32'(valid), 32'd0);

    // Publish on the same edge as the ack of the previous frame
    hold(2'b10, 7'h46, 4); hold(2'b01, 7'h21, 4); idle(2);
    hold(2'b10, 7'h06, 4); hold(2'b01, 7'h0E, 4);
    tick(2'b11, 7'h7F, 1'b0);
    tick(2'b11, 7'h7F, 1'b1);
    check("same_valid", 32'(valid), 32'd1);
    check("same_hex0", 32'(hex0), 32'hE);
    check("same_hex1", 32'(hex1), 32'hF);
    check("same_overrun", 32'(overrun), 32'd0);

    // Randomized streams
    for (int d = 0; d < 240; d++) begin
      logic [1:0] r_an;
      logic [6:0] r_sg;
      int         len;
      int         p;
      p = int'($urandom_range(0, 19));
      if (p == 0)      r_an = 2'b00;
      else if (p == 1) r_an = 2'b11;
      else             r_an = (d % 2 == 0) ? 2'b10 : 2'b01;
      if ($urandom_range(0, 9) == 0) r_sg = 7'($urandom);
      else r_sg = seg_tab[$urandom_range(0, 15)];
      len = int'($urandom_range(S - 1, S + 2));
      for (int c = 0; c < len; c++) tick(r_an, r_sg, ($urandom_range(0, 5) == 0));
      if (d == 120) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL timeout: simulation did not reach its end");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
